// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the camera frame sequencer.
package cam_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCfg,
      StFlush,
      StArm,
      StStream,
      StDone
   } cam_state_t;

   localparam int unsigned PIX_W            = 16;
   localparam int unsigned FRAME_PIXELS_DEF = 76800;

endpackage

// File: rtl/obuf_skid.sv
// Two-entry skid buffer between the FIFO read port and the frame-buffer write port.
// The head entry drives the registered output; a flush drops everything held.
module obuf_skid
   import cam_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [PIX_W-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [PIX_W-1:0] o_data,
   output logic [1:0]       o_count
);

   logic [1:0]       count_q, count_d;
   logic [PIX_W-1:0] head_q, head_d;
   logic [PIX_W-1:0] tail_q, tail_d;
   logic             pop;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      pop     = (count_q != 2'd0) && i_ready;
      if (i_flush) begin
         count_d = 2'd0;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         unique case ({i_valid, pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = i_data;
               else                 tail_d = i_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = i_data;
               end else begin
                  head_d = tail_q;
                  tail_d = i_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign o_valid = (count_q != 2'd0);
   assign o_data  = head_q;
   assign o_count = count_q;

endmodule

// File: rtl/cam_stream_ctrl.sv
// Frame sequencer: one-time camera config, FIFO flush, arm on SOF, then stream exactly
// one frame of pixels into the frame buffer with linear addresses and backpressure.
module cam_stream_ctrl
   import cam_ctrl_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter int unsigned ADDR_WIDTH   = 17,
   parameter int unsigned FLUSH_CYCLES = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_continuous,
   output logic                  o_cfg_init,
   input  logic                  i_cfg_done,
   input  logic                  i_sof,
   output logic                  o_flush,
   output logic                  o_obuf_rd,
   input  logic [PIX_W-1:0]      i_obuf_data,
   input  logic                  i_obuf_empty,
   output logic                  o_fb_wr,
   output logic [ADDR_WIDTH-1:0] o_fb_addr,
   output logic [PIX_W-1:0]      o_fb_data,
   input  logic                  i_fb_ready,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_frame_err
);

   localparam int unsigned FcW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FcW-1:0]        FlushLast = FcW'(FLUSH_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] LastPix   = ADDR_WIDTH'(FRAME_PIXELS - 1);
   localparam logic [ADDR_WIDTH:0]   FramePix  = (ADDR_WIDTH + 1)'(FRAME_PIXELS);

   cam_state_t            state_q, state_d;
   logic                  cfg_seen_q, cfg_seen_d;
   logic                  cfg_init_q, cfg_init_d;
   logic                  err_q, err_d;
   logic                  sof_pend_q, sof_pend_d;
   logic [FcW-1:0]        flush_cnt_q, flush_cnt_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  inflight_q, inflight_d;

   logic                  skid_flush;
   logic                  skid_valid;
   logic [PIX_W-1:0]      skid_data;
   logic [1:0]            skid_count;
   logic                  xfer;
   logic [2:0]            occ;
   logic                  obuf_rd;

   obuf_skid u_skid (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (skid_flush),
      .i_valid (inflight_q),
      .i_data  (i_obuf_data),
      .i_ready (i_fb_ready),
      .o_valid (skid_valid),
      .o_data  (skid_data),
      .o_count (skid_count)
   );

   assign xfer = skid_valid && i_fb_ready;
   // Skid occupancy net of this cycle's pop, so a full-rate stream keeps reading.
   assign occ  = 3'(skid_count) + 3'(inflight_q) - 3'(xfer);

   always_comb begin
      state_d     = state_q;
      cfg_seen_d  = cfg_seen_q;
      cfg_init_d  = 1'b0;
      err_d       = 1'b0;
      sof_pend_d  = 1'b0;
      flush_cnt_d = flush_cnt_q;
      issued_d    = issued_q;
      addr_d      = addr_q;
      inflight_d  = 1'b0;
      skid_flush  = 1'b0;
      obuf_rd     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               if (cfg_seen_q) begin
                  state_d     = StFlush;
                  flush_cnt_d = '0;
               end else begin
                  state_d    = StCfg;
                  cfg_init_d = 1'b1;
               end
            end
         end
         StCfg: begin
            if (i_cfg_done) begin
               cfg_seen_d  = 1'b1;
               state_d     = StFlush;
               flush_cnt_d = '0;
            end
         end
         StFlush: begin
            if (flush_cnt_q == FlushLast) state_d = StArm;
            else                          flush_cnt_d = flush_cnt_q + FcW'(1);
         end
         StArm: begin
            // Stale words are read out and dropped: inflight stays clear.
            obuf_rd = !i_obuf_empty;
            if (i_sof) begin
               state_d  = StStream;
               issued_d = '0;
               addr_d   = '0;
            end
         end
         StStream: begin
            obuf_rd    = !i_obuf_empty && (occ < 3'd2) && (issued_q < FramePix);
            inflight_d = obuf_rd;
            if (obuf_rd) issued_d = issued_q + (ADDR_WIDTH + 1)'(1);
            if (xfer) addr_d = addr_q + ADDR_WIDTH'(1);
            if (xfer && (addr_q == LastPix)) begin
               state_d    = StDone;
               addr_d     = '0;
               issued_d   = '0;
               sof_pend_d = i_sof;
            end else if (i_sof) begin
               state_d     = StFlush;
               flush_cnt_d = '0;
               err_d       = 1'b1;
               skid_flush  = 1'b1;
               addr_d      = '0;
               issued_d    = '0;
               inflight_d  = 1'b0;
            end
         end
         StDone: begin
            if (!i_continuous)                state_d = StIdle;
            else if (sof_pend_q || i_sof)     state_d = StStream;
            else                              state_d = StArm;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         cfg_seen_q  <= 1'b0;
         cfg_init_q  <= 1'b0;
         err_q       <= 1'b0;
         sof_pend_q  <= 1'b0;
         flush_cnt_q <= '0;
         issued_q    <= '0;
         addr_q      <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_seen_q  <= cfg_seen_d;
         cfg_init_q  <= cfg_init_d;
         err_q       <= err_d;
         sof_pend_q  <= sof_pend_d;
         flush_cnt_q <= flush_cnt_d;
         issued_q    <= issued_d;
         addr_q      <= addr_d;
         inflight_q  <= inflight_d;
      end
   end

   assign o_cfg_init   = cfg_init_q;
   assign o_flush      = (state_q == StFlush);
   assign o_obuf_rd    = obuf_rd;
   assign o_fb_wr      = skid_valid;
   assign o_fb_addr    = addr_q;
   assign o_fb_data    = skid_data;
   assign o_busy       = (state_q != StIdle);
   assign o_frame_done = (state_q == StDone);
   assign o_frame_err  = err_q;

endmodule

// File: tb/tb_cam_stream_ctrl.sv
// Randomized bench for cam_stream_ctrl with a queue-based FIFO and frame reference model.
module tb_cam_stream_ctrl;

   localparam int unsigned FP = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned FC = 8;

   logic          i_clk = 1'b0;
   logic          i_rst, i_start, i_continuous, i_cfg_done, i_sof;
   logic          i_obuf_empty, i_fb_ready;
   logic [15:0]   i_obuf_data;
   logic          o_cfg_init, o_flush, o_obuf_rd, o_fb_wr, o_busy, o_frame_done, o_frame_err;
   logic [AW-1:0] o_fb_addr;
   logic [15:0]   o_fb_data;

   cam_stream_ctrl #(
      .FRAME_PIXELS (FP),
      .ADDR_WIDTH   (AW),
      .FLUSH_CYCLES (FC)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_continuous (i_continuous),
      .o_cfg_init   (o_cfg_init),
      .i_cfg_done   (i_cfg_done),
      .i_sof        (i_sof),
      .o_flush      (o_flush),
      .o_obuf_rd    (o_obuf_rd),
      .i_obuf_data  (i_obuf_data),
      .i_obuf_empty (i_obuf_empty),
      .o_fb_wr      (o_fb_wr),
      .o_fb_addr    (o_fb_addr),
      .o_fb_data    (o_fb_data),
      .i_fb_ready   (i_fb_ready),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_frame_err  (o_frame_err)
   );

   always #5 i_clk = ~i_clk;

   logic [15:0]   fifo_q[$];
   logic [15:0]   exp_q[$];
   int            n_tests = 0, n_fail = 0, cyc_no = 0;
   int            n_cfg, n_flush, n_rd_flush, n_done, n_err, n_wr, exp_idx;
   int            first_rd, first_wr, last_wr, done_cyc;
   bit            capture = 1'b0, rand_ready = 1'b0, stall_prev = 1'b0;
   logic [15:0]   prev_data;
   logic [AW-1:0] prev_addr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   task automatic clear_stats();
      n_cfg = 0; n_flush = 0; n_rd_flush = 0; n_done = 0; n_err = 0; n_wr = 0;
      exp_idx = 0; first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
      exp_q.delete();
   endtask

   // One clock: monitor at the falling edge, FIFO read data lands #1 after the rising edge.
   task automatic cyc();
      logic        rd_now;
      logic [15:0] popped;
      popped = '0;
      i_obuf_empty = (fifo_q.size() == 0);
      if (rand_ready) i_fb_ready = ($urandom_range(0, 99) >= 30);
      @(negedge i_clk);
      cyc_no++;
      if (o_cfg_init)   n_cfg++;
      if (o_frame_done) begin n_done++; done_cyc = cyc_no; end
      if (o_frame_err)  n_err++;
      if (stall_prev) begin
         check_eq("hold_wr", 32'(o_fb_wr), 32'd1);
         check_eq("hold_addr", 32'(o_fb_addr), 32'(prev_addr));
         check_eq("hold_data", 32'(o_fb_data), 32'(prev_data));
      end
      if (o_fb_wr && i_fb_ready) begin
         if (!capture || exp_idx >= exp_q.size()) begin
            check_eq("stray_wr", 32'd1, 32'd0);
         end else begin
            check_eq("wr_addr", 32'(o_fb_addr), 32'(exp_idx));
            check_eq("wr_data", 32'(o_fb_data), 32'(exp_q[exp_idx]));
            exp_idx++;
         end
         if (n_wr == 0) first_wr = cyc_no;
         last_wr = cyc_no;
         n_wr++;
      end
      stall_prev = o_fb_wr && !i_fb_ready;
      prev_addr  = o_fb_addr;
      prev_data  = o_fb_data;
      rd_now = o_obuf_rd;
      if (rd_now) begin
         if (capture && first_rd < 0) first_rd = cyc_no;
         if (fifo_q.size() == 0) check_eq("rd_on_empty", 32'd1, 32'd0);
         else popped = fifo_q.pop_front();
      end
      if (o_flush) begin
         n_flush++;
         if (rd_now) n_rd_flush++;
         fifo_q.delete();
      end
      @(posedge i_clk);
      #1;
      if (rd_now) i_obuf_data = popped;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_cfg_init"}, 32'(o_cfg_init), 32'd0);
      check_eq({pfx, "_flush"}, 32'(o_flush), 32'd0);
      check_eq({pfx, "_obuf_rd"}, 32'(o_obuf_rd), 32'd0);
      check_eq({pfx, "_fb_wr"}, 32'(o_fb_wr), 32'd0);
      check_eq({pfx, "_fb_addr"}, 32'(o_fb_addr), 32'd0);
      check_eq({pfx, "_fb_data"}, 32'(o_fb_data), 32'd0);
      check_eq({pfx, "_busy"}, 32'(o_busy), 32'd0);
      check_eq({pfx, "_done"}, 32'(o_frame_done), 32'd0);
      check_eq({pfx, "_err"}, 32'(o_frame_err), 32'd0);
   endtask

   // SOF pulse, then a fresh frame of random pixels arrives in the FIFO.
   task automatic start_frame();
      clear_stats();
      i_sof = 1'b1;
      cyc();
      i_sof = 1'b0;
      for (int i = 0; i < FP; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      capture = 1'b1;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && n_done == 0; i++) cyc();
      check_eq("frame_done_cnt", 32'(n_done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_continuous = 1'b0; i_cfg_done = 1'b0; i_sof = 1'b0;
      i_obuf_empty = 1'b1; i_fb_ready = 1'b1; i_obuf_data = '0;
      clear_stats();
      cycles(2);
      check_all_zero("rst");
      i_rst = 1'b0;

      // Config handshake with cfg_done 20 cycles after start, then an 8-cycle flush.
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      check_eq("start_busy", 32'(o_busy), 32'd1);
      check_eq("start_cfg_init", 32'(o_cfg_init), 32'd1);
      cycles(19);
      i_cfg_done = 1'b1;
      cycles(12);
      check_eq("cfg_pulses", 32'(n_cfg), 32'd1);
      check_eq("flush_cycles", 32'(n_flush), FC);
      check_eq("rd_in_flush", 32'(n_rd_flush), 32'd0);
      check_eq("arm_flush", 32'(o_flush), 32'd0);
      check_eq("arm_busy", 32'(o_busy), 32'd1);

      // Stale words in ARM are drained and never written.
      for (int i = 0; i < 3; i++) fifo_q.push_back(16'hdead);
      cycles(6);
      check_eq("arm_drain", 32'(fifo_q.size()), 32'd0);

      // Full-rate frame; a stale word read on the SOF cycle must be dropped.
      fifo_q.push_back(16'hbeef);
      start_frame();
      run_until_done(60);
      capture = 1'b0;
      check_eq("f1_writes", 32'(n_wr), FP);
      check_eq("f1_latency", 32'(first_wr - first_rd), 32'd2);
      check_eq("f1_back2back", 32'(last_wr - first_wr), FP - 1);
      check_eq("f1_done_after_last", 32'(done_cyc - last_wr), 32'd1);
      check_eq("f1_idle_busy", 32'(o_busy), 32'd0);

      // Restart with config already seen: straight into flush.
      clear_stats();
      i_continuous = 1'b1;
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      check_eq("restart_cfg_init", 32'(o_cfg_init), 32'd0);
      check_eq("restart_flush", 32'(o_flush), 32'd1);
      cycles(10);
      check_eq("restart_flush_cycles", 32'(n_flush), FC);
      check_eq("restart_cfg_pulses", 32'(n_cfg), 32'd0);

      // Random backpressure.
      rand_ready = 1'b1;
      start_frame();
      run_until_done(300);
      capture = 1'b0;
      rand_ready = 1'b0;
      i_fb_ready = 1'b1;
      stall_prev = 1'b0;
      check_eq("f2_writes", 32'(n_wr), FP);
      check_eq("f2_rearm_busy", 32'(o_busy), 32'd1);
      check_eq("f2_rearm_flush", 32'(o_flush), 32'd0);

      // Early SOF after five pixels aborts the frame.
      start_frame();
      for (int i = 0; i < 40 && n_wr < 5; i++) cyc();
      check_eq("early_wr_count", 32'(n_wr), 32'd5);
      i_sof = 1'b1;
      cyc();
      i_sof = 1'b0;
      capture = 1'b0;
      check_eq("early_err", 32'(o_frame_err), 32'd1);
      check_eq("early_flush", 32'(o_flush), 32'd1);
      cycles(20);
      check_eq("early_err_cnt", 32'(n_err), 32'd1);
      check_eq("early_no_done", 32'(n_done), 32'd0);

      // Reset mid-stream, then config is requested again.
      start_frame();
      cycles(4);
      i_rst = 1'b1;
      cyc();
      capture = 1'b0;
      stall_prev = 1'b0;
      check_all_zero("midrst");
      i_rst = 1'b0;
      fifo_q.delete();
      clear_stats();
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      check_eq("post_rst_cfg_init", 32'(o_cfg_init), 32'd1);
      cycles(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
